// File: rtl/cache_ctrl_pkg.sv
// Shared constants, types and helpers for the cache replacement control path.
package cache_ctrl_pkg;

    localparam int unsigned NUM_WAYS = 3;
    localparam int unsigned DEPTH    = 2;
    localparam int unsigned SRC_W    = 2;

    typedef logic [SRC_W-1:0] src_idx_t;

    // Next round-robin start position: (idx + 1) mod 3.
    function automatic src_idx_t rr_next(input src_idx_t idx);
        return (idx >= SRC_W'(NUM_WAYS - 1)) ? '0 : idx + SRC_W'(1);
    endfunction

    // (base + off) mod 3 for small operands.
    function automatic src_idx_t rr_offset(input src_idx_t base, input src_idx_t off);
        logic [2:0] sum;
        sum = 3'(base) + 3'(off);
        if (sum >= 3'(NUM_WAYS)) begin
            sum = sum - 3'(NUM_WAYS);
        end
        return SRC_W'(sum);
    endfunction

endpackage

// File: rtl/cache_rr_arb3.sv
// Combinational 3-way round-robin arbiter: one-hot grant to the first requester at or after ptr.
module cache_rr_arb3
    import cache_ctrl_pkg::*;
(
    input  logic [NUM_WAYS-1:0] req,
    input  src_idx_t            ptr,
    output logic [NUM_WAYS-1:0] grant
);

    logic     found;
    src_idx_t idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            idx = rr_offset(ptr, SRC_W'(i));
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_merge3_sync.sv
// 3-to-1 round-robin merge into a 2-entry FIFO; each head entry carries its source index.
module cache_merge3_sync
    import cache_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_drive0,
    input  logic              i_drive1,
    input  logic              i_drive2,
    input  logic [DATA_W-1:0] i_data0,
    input  logic [DATA_W-1:0] i_data1,
    input  logic [DATA_W-1:0] i_data2,
    output logic              o_free0,
    output logic              o_free1,
    output logic              o_free2,
    output logic              o_driveNext,
    output logic [DATA_W-1:0] o_dataNext,
    output logic [1:0]        o_srcNext,
    input  logic              i_freeNext,
    output logic              o_fire,
    output logic [1:0]        o_count
);

    logic [NUM_WAYS-1:0] req;
    logic [NUM_WAYS-1:0] grant;
    logic [NUM_WAYS-1:0] free;
    logic [DATA_W-1:0]   in_data [NUM_WAYS];
    src_idx_t            rr_ptr;
    src_idx_t            grant_idx;
    logic                full;
    logic                push;
    logic                pop;

    logic [DATA_W-1:0]   mem_data [DEPTH];
    src_idx_t            mem_src  [DEPTH];
    logic                wr_ptr;
    logic                rd_ptr;
    logic [1:0]          count;

    assign req        = {i_drive2, i_drive1, i_drive0};
    assign in_data[0] = i_data0;
    assign in_data[1] = i_data1;
    assign in_data[2] = i_data2;

    cache_rr_arb3 u_arb (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    // Full is judged on registered occupancy only; a same-cycle pop does not reopen the input.
    assign full = (count == 2'(DEPTH));
    assign free = (rst && !full) ? grant : '0;
    assign {o_free2, o_free1, o_free0} = free;
    assign push   = |(req & free);
    assign o_fire = push;

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (grant[i]) begin
                grant_idx = SRC_W'(i);
            end
        end
    end

    // Head outputs are forced to zero while empty or in reset.
    assign o_driveNext = rst && (count != 2'd0);
    assign pop         = o_driveNext && i_freeNext;
    assign o_dataNext  = o_driveNext ? mem_data[rd_ptr] : '0;
    assign o_srcNext   = o_driveNext ? mem_src[rd_ptr] : '0;
    assign o_count     = rst ? count : 2'd0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count  <= 2'd0;
            rr_ptr <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_src[i]  <= '0;
            end
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= in_data[grant_idx];
                mem_src[wr_ptr]  <= grant_idx;
                wr_ptr           <= ~wr_ptr;
                rr_ptr           <= rr_next(grant_idx);
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_merge3_sync.sv
// Randomized and directed bench for cache_merge3_sync against a queue-based reference model.
module tb_cache_merge3_sync;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  drv;
    logic [31:0] dat [3];
    logic        free_next;

    logic        o_free0, o_free1, o_free2;
    logic        o_driveNext;
    logic [31:0] o_dataNext;
    logic [1:0]  o_srcNext;
    logic        o_fire;
    logic [1:0]  o_count;

    always #5 clk = ~clk;

    cache_merge3_sync #(.DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_drive0    (drv[0]),
        .i_drive1    (drv[1]),
        .i_drive2    (drv[2]),
        .i_data0     (dat[0]),
        .i_data1     (dat[1]),
        .i_data2     (dat[2]),
        .o_free0     (o_free0),
        .o_free1     (o_free1),
        .o_free2     (o_free2),
        .o_driveNext (o_driveNext),
        .o_dataNext  (o_dataNext),
        .o_srcNext   (o_srcNext),
        .i_freeNext  (free_next),
        .o_fire      (o_fire),
        .o_count     (o_count)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: FIFO of {src, data} and the round-robin start position.
    logic [33:0] q [$];
    int          rr = 0;

    logic [2:0]  cap_free;
    logic        cap_fire;
    logic        cap_drive;
    logic [31:0] cap_data;
    logic [1:0]  cap_src;
    logic [1:0]  cap_count;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: settle, compare every output with the model, advance the model, move to next negedge.
    task automatic step();
        int         g;
        logic [2:0] ef;
        logic       efire;
        logic       edrv;
        logic [33:0] head;
        #1;
        cap_free  = {o_free2, o_free1, o_free0};
        cap_fire  = o_fire;
        cap_drive = o_driveNext;
        cap_data  = o_dataNext;
        cap_src   = o_srcNext;
        cap_count = o_count;

        g  = -1;
        ef = 3'b000;
        if (rst && q.size() < 2) begin
            for (int k = 0; k < 3; k++) begin
                int c;
                c = (rr + k) % 3;
                if (g < 0 && drv[c]) g = c;
            end
        end
        if (g >= 0) ef[g] = 1'b1;
        efire = (g >= 0);
        edrv  = rst && (q.size() > 0);

        chk("free", 64'(cap_free), 64'(ef));
        chk("fire", 64'(cap_fire), 64'(efire));
        chk("drive", 64'(cap_drive), 64'(edrv));
        chk("count", 64'(cap_count), rst ? 64'(q.size()) : 64'd0);
        if (edrv) begin
            head = q[0];
            chk("data", 64'(cap_data), 64'(head[31:0]));
            chk("src", 64'(cap_src), 64'(head[33:32]));
        end

        if (!rst) begin
            q.delete();
            rr = 0;
        end else begin
            if (edrv && free_next) void'(q.pop_front());
            if (g >= 0) begin
                q.push_back({2'(g), dat[g]});
                rr = (g + 1) % 3;
            end
        end

        @(negedge clk);
        if (g >= 0) drv[g] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drv = 3'b000;
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
        int          srcs [6];
        int          ns;
        int          p_req;
        int          p_pop;
        logic [31:0] base;

        rst       = 1'b0;
        drv       = 3'b000;
        free_next = 1'b0;
        for (int k = 0; k < 3; k++) dat[k] = '0;
        @(negedge clk);

        // Reset with every input requesting.
        drv = 3'b111;
        dat[0] = 32'h11; dat[1] = 32'h22; dat[2] = 32'h33;
        free_next = 1'b1;
        step();
        step();
        chk("rst_free", 64'(cap_free), 64'd0);
        chk("rst_drive", 64'(cap_drive), 64'd0);
        chk("rst_count", 64'(cap_count), 64'd0);

        // Round-robin with all three continuously requesting.
        rst = 1'b1;
        ns  = 0;
        for (int n = 0; n < 7; n++) begin
            for (int k = 0; k < 3; k++) begin
                if (!drv[k]) begin
                    drv[k] = 1'b1;
                    dat[k] = 32'h1000 * 32'(n) + 32'(k);
                end
            end
            step();
            if (n == 0) chk("rr_first_grant", 64'(cap_free), 64'b001);
            chk("rr_fire", 64'(cap_fire), 64'd1);
            if (n >= 1 && cap_drive && ns < 6) begin
                srcs[ns] = int'(cap_src);
                ns++;
            end
        end
        chk("rr_seen", 64'(ns), 64'd6);
        for (int i = 0; i < 6; i++) chk("rr_order", 64'(srcs[i]), 64'(i % 3));

        // Single source: latency of one cycle to the head.
        do_reset();
        free_next = 1'b1;
        drv[1] = 1'b1;
        dat[1] = 32'hA5A5A5A5;
        step();
        chk("single_free", 64'(cap_free), 64'b010);
        chk("single_fire", 64'(cap_fire), 64'd1);
        step();
        chk("single_drive", 64'(cap_drive), 64'd1);
        chk("single_data", 64'(cap_data), 64'hA5A5A5A5);
        chk("single_src", 64'(cap_src), 64'd1);

        // Full and backpressure.
        do_reset();
        free_next = 1'b0;
        drv = 3'b101;
        dat[0] = 32'hD000_0000;
        dat[2] = 32'hD000_0002;
        step();
        chk("full_g0", 64'(cap_free), 64'b001);
        step();
        chk("full_g2", 64'(cap_free), 64'b100);
        chk("full_cnt1", 64'(cap_count), 64'd1);
        drv[0] = 1'b1;
        dat[0] = 32'hD000_0010;
        step();
        chk("full_cnt2", 64'(cap_count), 64'd2);
        chk("full_block", 64'(cap_free), 64'd0);
        free_next = 1'b1;
        step();
        chk("pop_no_bypass", 64'(cap_free), 64'd0);
        chk("pop_head_src", 64'(cap_src), 64'd0);
        free_next = 1'b0;
        step();
        chk("resume_cnt", 64'(cap_count), 64'd1);
        chk("resume_free", 64'(cap_free), 64'b001);
        step();
        chk("refill_cnt", 64'(cap_count), 64'd2);

        // Reset mid-operation with two buffered entries.
        rst = 1'b0;
        drv = 3'b000;
        step();
        rst = 1'b1;
        step();
        chk("midrst_drive", 64'(cap_drive), 64'd0);
        chk("midrst_count", 64'(cap_count), 64'd0);
        free_next = 1'b1;
        step();
        chk("midrst_empty", 64'(cap_drive), 64'd0);

        // Simultaneous push and pop at occupancy one.
        do_reset();
        free_next = 1'b0;
        base = 32'hE000_0000;
        drv[1] = 1'b1;
        dat[1] = base;
        step();
        free_next = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drv[1] = 1'b1;
            dat[1] = base + 32'(i);
            step();
            chk("pp_count", 64'(cap_count), 64'd1);
            chk("pp_data", 64'(cap_data), 64'(base + 32'(i - 1)));
            chk("pp_fire", 64'(cap_fire), 64'd1);
        end

        // Randomized traffic with occasional resets.
        do_reset();
        p_req = 50;
        p_pop = 50;
        for (int n = 0; n < 4000; n++) begin
            if (n % 400 == 0) begin
                p_req = $urandom_range(100, 5);
                p_pop = $urandom_range(100, 5);
            end
            for (int k = 0; k < 3; k++) begin
                if (!drv[k] && $urandom_range(99, 0) < p_req) begin
                    drv[k] = 1'b1;
                    dat[k] = $urandom;
                end
            end
            free_next = ($urandom_range(99, 0) < p_pop);
            rst = ($urandom_range(299, 0) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
